// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO plus a transmit sequencer sitting in front of a UART transmitter.
// Producers push bytes at clock rate; the sequencer pops one byte at a time and
// hands it to the UART through a tx_start pulse, then waits for the UART to
// report busy and go idle again before sending the next byte.
//
// Handshakes:
//   Write side : a byte is taken on every rising edge where wr_en=1 and full=0.
//                wr_en=1 while full=1 drops the byte and raises overflow for
//                exactly the following cycle. There is no back-pressure beyond
//                the full flag.
//   UART side  : tx_data is loaded on the pop and stays fixed until the next
//                pop. tx_start is high for exactly one cycle per byte. The UART
//                acknowledges by raising tx_busy; if that rise is never seen
//                within ACK_TIMEOUT cycles the sequencer moves on anyway, and it
//                only starts the next byte once tx_busy is low.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   wr_data   in   [7:0] byte to enqueue
//   wr_en     in   enqueue strobe
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds no bytes
//   count     out  [ADDR_WIDTH:0] occupancy 0..DEPTH
//   overflow  out  one-cycle pulse after a dropped write
//   tx_start  out  one-cycle start pulse to the UART
//   tx_data   out  [7:0] byte presented to the UART
//   tx_busy   in   UART transmitter busy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH       = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int ACK_TIMEOUT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_busy
);

   // Ack counter runs 0..ACK_TIMEOUT-1 while waiting in S_ACK.
   localparam int ACK_CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SEND  = 4'b0010,
      S_ACK   = 4'b0100,
      S_DRAIN = 4'b1000
   } state_t;

   state_t                state;
   state_t                next_state;

   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ACK_CW-1:0]     ack_cnt;

   logic                  wr_accept;
   logic                  pop;
   logic                  ack_clr;
   logic                  ack_inc;

   // full/empty come straight from the registered count, so a write in a full
   // cycle is refused even when the sequencer pops in that same cycle.
   assign full      = (count == (ADDR_WIDTH+1)'(DEPTH));
   assign empty     = (count == '0);
   assign wr_accept = wr_en & ~full;

   // ---------------------------------------------------------------------------
   // Storage (no reset: contents are meaningless until written)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, occupancy, overflow flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en & full;
         if (wr_accept) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         case ({wr_accept, pop})
            2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer: state register, ack counter and registered UART outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ack_cnt  <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state <= next_state;
         // tx_start is high exactly while the state register holds S_SEND.
         tx_start <= (next_state == S_SEND);
         if (pop) begin
            tx_data <= mem[rd_ptr];
         end
         if (ack_clr) begin
            ack_cnt <= '0;
         end else if (ack_inc) begin
            ack_cnt <= ack_cnt + ACK_CW'(1);
         end
      end
   end

   always_comb begin
      next_state = S_IDLE;
      pop        = 1'b0;
      ack_clr    = 1'b0;
      ack_inc    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = S_SEND;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_SEND: begin
            ack_clr    = 1'b1;
            next_state = S_ACK;
         end
         S_ACK: begin
            // Give up waiting after ACK_TIMEOUT cycles so a busy pulse that
            // was missed cannot stall the queue forever.
            if (tx_busy) begin
               next_state = S_DRAIN;
            end else if (ack_cnt == ACK_CW'(ACK_TIMEOUT - 1)) begin
               next_state = S_DRAIN;
            end else begin
               ack_inc    = 1'b1;
               next_state = S_ACK;
            end
         end
         S_DRAIN: begin
            next_state = tx_busy ? S_DRAIN : S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo. The reference model is a byte queue of accepted
// writes plus two counters (bytes accepted, start pulses seen); occupancy is
// accepted minus started, and every start pulse must carry the head of the
// queue. A small UART model raises tx_busy one cycle after each start and
// drops it frame_len cycles later.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int DEPTH       = 16;
   localparam int ADDR_WIDTH  = 4;
   localparam int ACK_TIMEOUT = 3;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic                clk = 1'b0;
   logic                reset;
   logic [7:0]          wr_data;
   logic                wr_en;
   logic                full;
   logic                empty;
   logic [ADDR_WIDTH:0] count;
   logic                overflow;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DEPTH       (DEPTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state and counters
   // ---------------------------------------------------------------------------
   int         compared   = 0;
   int         mismatched = 0;

   logic [7:0] exp_q[$];
   int         accepted   = 0;
   int         starts     = 0;
   logic       drop_pending = 1'b0;
   int         ovf_pulses = 0;
   int         peak_count = 0;

   int         cyc = 0;
   int         last_start_cyc = 0;
   int         last_gap = 0;
   logic       have_last = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic       prev_start = 1'b0;

   // UART model
   logic       model_busy  = 1'b0;
   logic       hold_busy   = 1'b0;
   logic       no_busy     = 1'b0;
   logic       rise_pending = 1'b0;
   int         busy_left   = 0;
   int         frame_len   = 20;

   assign tx_busy = model_busy | hold_busy;

   always @(posedge clk) cyc++;

   // ---------------------------------------------------------------------------
   // Monitor: runs on the falling edge, away from the DUT's active edge
   // ---------------------------------------------------------------------------
   logic [7:0] exp_b;
   int         occ;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (model_busy) begin
            if (busy_left == 0) model_busy = 1'b0;
            else busy_left--;
         end
         if (rise_pending) begin
            model_busy   = 1'b1;
            busy_left    = frame_len;
            rise_pending = 1'b0;
         end

         if (tx_start === 1'b1) begin
            starts++;
            compared++;
            if (prev_start) begin
               mismatched++;
               $display("FAIL start_width: tx_start high two cycles running at cyc %0d", cyc);
            end
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL start_extra: tx_start with no byte queued, tx_data=%02h", tx_data);
            end else begin
               exp_b = exp_q.pop_front();
               if (tx_data !== exp_b) begin
                  mismatched++;
                  $display("FAIL start_data: tx_data=%02h expected %02h", tx_data, exp_b);
               end
            end
            compared++;
            if (model_busy) begin
               mismatched++;
               $display("FAIL start_busy: tx_start while UART still busy at cyc %0d", cyc);
            end
            if (have_last) begin
               last_gap = cyc - last_start_cyc;
               compared++;
               if (last_gap < 4) begin
                  mismatched++;
                  $display("FAIL start_gap: spacing %0d cycles, required >= 4", last_gap);
               end
            end
            last_start_cyc = cyc;
            have_last      = 1'b1;
            last_data      = tx_data;
            if (!no_busy) rise_pending = 1'b1;
         end else begin
            compared++;
            if (tx_data !== last_data) begin
               mismatched++;
               $display("FAIL data_hold: tx_data=%02h changed without start, expected %02h",
                        tx_data, last_data);
            end
         end

         occ = accepted - starts;
         compared++;
         if (count !== (ADDR_WIDTH+1)'(occ)) begin
            mismatched++;
            $display("FAIL count: count=%0d expected %0d at cyc %0d", count, occ, cyc);
         end
         compared++;
         if (empty !== (occ == 0) || full !== (occ == DEPTH)) begin
            mismatched++;
            $display("FAIL flags: empty=%b full=%b expected empty=%b full=%b",
                     empty, full, occ == 0, occ == DEPTH);
         end
         compared++;
         if (overflow !== drop_pending) begin
            mismatched++;
            $display("FAIL overflow: overflow=%b expected %b at cyc %0d", overflow, drop_pending, cyc);
         end
         drop_pending = 1'b0;
         if (overflow === 1'b1) ovf_pulses++;
         if (int'(count) > peak_count) peak_count = int'(count);
         prev_start = tx_start;
      end else begin
         prev_start = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic drive_write(input logic [7:0] b);
      @(negedge clk);
      #2;
      wr_en   = 1'b1;
      wr_data = b;
      // A write is taken only if the FIFO is not already holding DEPTH bytes.
      if (accepted - starts < DEPTH) begin
         exp_q.push_back(b);
         accepted++;
      end else begin
         drop_pending = 1'b1;
      end
   endtask

   task automatic drive_idle();
      @(negedge clk);
      #2;
      wr_en   = 1'b0;
      wr_data = 8'($urandom);
   endtask

   task automatic wait_drained(input int budget, input string tag);
      int n;
      n = 0;
      while ((accepted != starts || model_busy || rise_pending || hold_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= budget) begin
         mismatched++;
         $display("FAIL %s_drain: %0d bytes still queued after %0d cycles", tag, accepted - starts, budget);
      end
      repeat (8) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      #1;
      compared++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_out: tx_start=%b tx_data=%02h overflow=%b expected 0/00/0",
                  tx_start, tx_data, overflow);
      end
      compared++;
      if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_fifo: count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
      end
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int s0;
      int wcyc;
      frame_len = 1000;
      s0 = starts;
      drive_write(8'h48);
      wcyc = cyc;
      drive_idle();
      wait_drained(1200, "single");
      compared++;
      if (starts - s0 != 1) begin
         mismatched++;
         $display("FAIL single_count: %0d start pulses, expected 1", starts - s0);
      end
      compared++;
      if (last_start_cyc != wcyc + 2) begin
         mismatched++;
         $display("FAIL single_latency: start at cycle %0d, expected %0d", last_start_cyc, wcyc + 2);
      end
      compared++;
      if (tx_data !== 8'h48 || empty !== 1'b1) begin
         mismatched++;
         $display("FAIL single_end: tx_data=%02h empty=%b expected 48/1", tx_data, empty);
      end
   endtask

   task automatic test_burst_order();
      logic [7:0] msg [11];
      int s0;
      msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};
      frame_len  = 20;
      peak_count = 0;
      s0 = starts;
      for (int i = 0; i < 11; i++) drive_write(msg[i]);
      drive_idle();
      wait_drained(2000, "burst");
      compared++;
      if (starts - s0 != 11) begin
         mismatched++;
         $display("FAIL burst_count: %0d start pulses, expected 11", starts - s0);
      end
      compared++;
      if (peak_count != 10 && peak_count != 11) begin
         mismatched++;
         $display("FAIL burst_peak: peak count %0d, expected 10 or 11", peak_count);
      end
   endtask

   task automatic test_overflow();
      int s0;
      logic [7:0] first_b;
      frame_len  = 10;
      ovf_pulses = 0;
      s0 = starts;
      @(negedge clk);
      #2;
      hold_busy = 1'b1;
      first_b = 8'($urandom);
      drive_write(first_b);
      for (int i = 1; i < 18; i++) drive_write(8'($urandom));
      drive_idle();
      repeat (3) @(negedge clk);
      #1;
      compared++;
      if (count !== 5'd16 || full !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_full: count=%0d full=%b expected 16/1", count, full);
      end
      compared++;
      if (ovf_pulses != 1) begin
         mismatched++;
         $display("FAIL ovf_pulses: %0d overflow pulses, expected 1", ovf_pulses);
      end
      compared++;
      if (starts - s0 != 1 || tx_data !== first_b) begin
         mismatched++;
         $display("FAIL ovf_first: starts=%0d tx_data=%02h expected 1/%02h", starts - s0, tx_data, first_b);
      end
      #1;
      hold_busy = 1'b0;
      wait_drained(2000, "ovf");
      compared++;
      if (starts - s0 != 17) begin
         mismatched++;
         $display("FAIL ovf_sent: %0d bytes sent, expected 17", starts - s0);
      end
   endtask

   task automatic test_wrap();
      int s0;
      int sent;
      int n;
      int guard;
      peak_count = 0;
      ovf_pulses = 0;
      s0   = starts;
      sent = 0;
      while (sent < 40) begin
         frame_len = $urandom_range(1, 6);
         n = $urandom_range(1, 7);
         if (n > 40 - sent) n = 40 - sent;
         guard = 0;
         while (accepted - starts > 8 && guard < 500) begin
            @(negedge clk);
            guard++;
         end
         for (int i = 0; i < n; i++) drive_write(8'($urandom));
         drive_idle();
         sent += n;
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      wait_drained(2000, "wrap");
      compared++;
      if (starts - s0 != 40) begin
         mismatched++;
         $display("FAIL wrap_count: %0d bytes sent, expected 40", starts - s0);
      end
      compared++;
      if (peak_count > DEPTH || ovf_pulses != 0) begin
         mismatched++;
         $display("FAIL wrap_bounds: peak=%0d overflows=%0d expected <=16/0", peak_count, ovf_pulses);
      end
   endtask

   task automatic test_ack_timeout();
      int s0;
      no_busy = 1'b1;
      s0 = starts;
      drive_write(8'($urandom));
      drive_write(8'($urandom));
      drive_idle();
      wait_drained(200, "ack");
      compared++;
      if (starts - s0 != 2) begin
         mismatched++;
         $display("FAIL ack_count: %0d start pulses, expected 2", starts - s0);
      end
      compared++;
      if (last_gap != ACK_TIMEOUT + 3) begin
         mismatched++;
         $display("FAIL ack_gap: spacing %0d cycles, expected %0d", last_gap, ACK_TIMEOUT + 3);
      end
      no_busy = 1'b0;
   endtask

   task automatic test_async_reset();
      int guard;
      frame_len = 300;
      for (int i = 0; i < 6; i++) drive_write(8'($urandom));
      drive_idle();
      guard = 0;
      while (!model_busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (20) @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      compared++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0 ||
          count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset: start=%b data=%02h ovf=%b count=%0d empty=%b full=%b expected 0/00/0/0/1/0",
                  tx_start, tx_data, overflow, count, empty, full);
      end
      exp_q.delete();
      accepted     = 0;
      starts       = 0;
      have_last    = 1'b0;
      last_data    = 8'h00;
      model_busy   = 1'b0;
      rise_pending = 1'b0;
      drop_pending = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if (tx_start !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_glitch: tx_start=%b during reset, expected 0", tx_start);
         end
      end
      #2;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      compared++;
      if (starts != 0) begin
         mismatched++;
         $display("FAIL reset_idle: %0d start pulses without a write, expected 0", starts);
      end
      frame_len = 10;
      drive_write(8'hA5);
      drive_idle();
      wait_drained(200, "post_reset");
      compared++;
      if (starts != 1 || last_data !== 8'hA5) begin
         mismatched++;
         $display("FAIL reset_first: starts=%0d first byte %02h, expected 1/a5", starts, last_data);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_burst_order();
      test_overflow();
      test_wrap();
      test_ack_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
